qc_ldpc_syndrome_checker: RTL
=============================

Name: qc_ldpc_syndrome_checker

Overview:
Receive-side counterpart of the QC-LDPC encoder controller. It accepts a received hard-decision codeword one Z-bit column block per cycle (24 blocks) and computes the syndrome s = H·cᵀ over GF(2), one Z-bit sub-syndrome per prototype row. It reports whether the codeword is valid. It sits after the demapper/slicer and gates the bit-flipping decoder, which is invoked only when syndrome_ok=0.

Parameters:
NUM_OF_SUPPORTED_Z, 3, number of selectable lifting sizes
Z_VALUE_ARRAY, {27,54,81}, supported Z values, indexed by the z_sel one-hot bit position
HIGHEST_SUPPORTED_Z_VAL, 81, MaxZ; datapath width per block
NUM_INFO_BLKS_PER_CODE_BLK, 20, info column blocks
NUM_PARITY_BLKS_PER_CODE_BLK, 4, prototype rows (parity blocks)

Ports:
CLK  in  1  clock
rst_n  in  1  reset: synchronous, active-low
start  in  1  frame start pulse; sampled only in IDLE
z_sel  in  NUM_OF_SUPPORTED_Z  one-hot Z select, sampled with start
busy  out  1  high in any state other than IDLE
cfg_err  out  1  one-cycle pulse: start seen with z_sel not one-hot
in_valid  in  1  column block valid
in_ready  out  1  column block accept
in_data  in  MaxZ  column block; bits [MaxZ-1:Z] ignored
out_valid  out  1  syndrome result valid
out_ready  in  1  result accept
syndrome  out  NumPBlks*MaxZ  row r occupies [r*MaxZ +: MaxZ]; bits ≥ Z within each slice are 0
syndrome_ok  out  1  1 when the syndrome is entirely zero; valid with out_valid

Behaviour:
- Reset (rst_n=0 at a CLK edge) has priority over everything, including a frame in progress:
  - State goes to IDLE.
  - busy=0, cfg_err=0, in_ready=0, out_valid=0, syndrome=0, syndrome_ok=0.
  - Column counter and pipeline valid are cleared.
- States:
  - IDLE:
    - start with one-hot z_sel: latch Z index, clear accumulators, col=0, go to ACCUM.
    - start with non-one-hot z_sel: pulse cfg_err for one cycle and stay in IDLE.
  - ACCUM: in_ready=1. Each in_valid&in_ready handshake pushes (in_data masked to Z, col) into stage 1 and increments col. The handshake at col=23 moves to DRAIN.
  - DRAIN: in_ready=0 for one cycle while stage 2 retires the last column, then go to DONE.
  - DONE:
    - out_valid=1; syndrome and syndrome_ok are held stable until out_ready.
    - On handshake, go to IDLE and deassert out_valid.
- start is ignored outside IDLE. In IDLE in_ready=0, so a column presented together with start is not consumed.
- Pipeline:
  - Stage 1 registers the masked data and column index, and looks up the shift LUT at {z_idx, col}.
  - Stage 2, for each row r with a non-null shift s: acc[r] ^= rot_Z(data, s), where rot_Z(d,s)[i] = d[(i+s) mod Z] for i < Z. A null entry leaves acc[r] unchanged.
- Latency: out_valid rises 2 cycles after the edge that accepts the 24th column.
- syndrome_ok is registered together with syndrome and equals the NOR of all accumulator bits.
- Gaps in in_valid stall the column count only. There is no timeout.
- Shift arithmetic:
  - Shift width is $clog2(MaxZ).
  - Null is encoded as all-ones (127 for MaxZ=81).
  - Non-null values are always < Z.
  - The rotation is modulo the selected Z, not modulo MaxZ.

Decomposition:
- Package qc_ldpc_pkg:
  - Z_VALUE_ARRAY default, MaxZ, block counts.
  - SHIFT_W and the SHIFT_NULL constant.
  - State enum typedef {IDLE, ACCUM, DRAIN, DONE}.
  - rot_z function.
- Sub-module qc_ldpc_shift_lut: combinational ROM.
  - Inputs: z_idx, col. Output: NumPBlks shift values.
  - Holds the IEEE 802.11n rate-5/6 prototype matrices for n=648/1296/1944.
  - Shared with the encoder ROM contents.

Test Plan:
- z_sel=001 (Z=27), 24 all-zero columns, out_ready=1 → out_valid 2 cycles after the 24th accept; syndrome=0; syndrome_ok=1; back to IDLE the next cycle.
- z_sel=100 (Z=81), column 0 = 1<<0, others 0 → for each row r with LUT shift s≠null, only syndrome bit r*81+((81-s)%81) is set; null rows are 0; syndrome_ok=0. Checked against the golden model.
- z_sel=010 (Z=54):
  - Codeword produced by QCLDPCEncoderController with the same Z → syndrome_ok=1.
  - Same codeword with in_data[80:54] forced to all-ones → syndrome_ok=1 (upper bits ignored).
- Random in_valid gaps (50%) plus out_ready held low for 10 cycles in DONE → result identical to the gap-free run; syndrome stable and out_valid high throughout the stall.
- start with z_sel=011 → cfg_err=1 for exactly one cycle; busy=0; in_ready stays 0. Then start with z_sel=001 → normal frame.
- rst_n=0 for one cycle after 12 accepted columns → next cycle busy=0, out_valid=0, syndrome=0. A following full all-zero frame returns syndrome_ok=1.

Source files
------------

// File: rtl/qc_ldpc_pkg.sv
// Shared constants, state encoding and GF(2) circulant helpers for the QC-LDPC
// syndrome checker (802.11n rate-5/6 codes, Z in {27,54,81}).
package qc_ldpc_pkg;

    localparam int NUM_OF_SUPPORTED_Z           = 3;
    localparam int Z_VALUE_ARRAY [NUM_OF_SUPPORTED_Z] = '{27, 54, 81};
    localparam int HIGHEST_SUPPORTED_Z_VAL      = 81;
    localparam int MAX_Z                        = HIGHEST_SUPPORTED_Z_VAL;
    localparam int NUM_INFO_BLKS_PER_CODE_BLK   = 20;
    localparam int NUM_PARITY_BLKS_PER_CODE_BLK = 4;
    localparam int NUM_COLS  = NUM_INFO_BLKS_PER_CODE_BLK + NUM_PARITY_BLKS_PER_CODE_BLK;
    localparam int COL_W     = $clog2(NUM_COLS);
    localparam int SHIFT_W   = $clog2(MAX_Z);
    localparam logic [SHIFT_W-1:0] SHIFT_NULL = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    function automatic logic [SHIFT_W-1:0] z_of_idx(input logic [1:0] idx);
        logic [SHIFT_W-1:0] z;
        case (idx)
            2'd0:    z = SHIFT_W'(Z_VALUE_ARRAY[0]);
            2'd1:    z = SHIFT_W'(Z_VALUE_ARRAY[1]);
            default: z = SHIFT_W'(Z_VALUE_ARRAY[2]);
        endcase
        return z;
    endfunction

    function automatic logic [MAX_Z-1:0] z_mask(input logic [SHIFT_W-1:0] z);
        logic [MAX_Z-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_Z; i++)
            if (8'(i) < {1'b0, z}) m[i] = 1'b1;
        return m;
    endfunction

    // Circulant rotation modulo the active Z: r[i] = d[(i+s) mod z], bits >= z are zero.
    function automatic logic [MAX_Z-1:0] rot_z(input logic [MAX_Z-1:0] d,
                                               input logic [SHIFT_W-1:0] s,
                                               input logic [SHIFT_W-1:0] z);
        logic [MAX_Z-1:0] r;
        logic [7:0]       k;
        r = '0;
        for (int i = 0; i < MAX_Z; i++) begin
            k = 8'(i) + {1'b0, s};
            if (k >= {1'b0, z}) k = k - {1'b0, z};
            if (8'(i) < {1'b0, z}) r[i] = d[k[SHIFT_W-1:0]];
        end
        return r;
    endfunction

endpackage

// File: rtl/qc_ldpc_shift_lut.sv
// Combinational prototype-matrix ROM: circulant shift of every parity row for a
// given Z index and column block (802.11n rate 5/6, n = 648/1296/1944).
module qc_ldpc_shift_lut
    import qc_ldpc_pkg::*;
(
    input  logic [1:0]                                        z_idx,
    input  logic [COL_W-1:0]                                  col,
    output logic [NUM_PARITY_BLKS_PER_CODE_BLK*SHIFT_W-1:0]   shifts
);

    localparam int N = -1;
    localparam int H_TAB [NUM_OF_SUPPORTED_Z][NUM_PARITY_BLKS_PER_CODE_BLK][NUM_COLS] = '{
        '{  // n=648, Z=27
            '{17,13, 8,21, 9, 3,18,12,10, 0, 4,15,19, 2, 5,10,26,19,13,13, 1, 0, N, N},
            '{ 3,12,11,14,11,25, 5,18, 0, 9, 2,26,26,10,24, 7,14,20, 4, 2, N, 0, 0, N},
            '{22,16, 4, 3,10,21,12, 5,21,14,19, 5, N, 8, 5,18,11, 5, 5,15, 0, N, 0, 0},
            '{ 7, 7,14,14, 4,16,16,24,24,10, 1, 7,15, 6,10,26, 8,18,21,14, 1, N, N, 0}
        },
        '{  // n=1296, Z=54
            '{48,29,37,52, 2,16, 6,14,53,31,34, 5,18,42,53,31,45, N,46,52, 1, 0, N, N},
            '{17, 4,30, 7,43,11,24, 6,14,21, 6,39,17,40,47, 7,15,41,19, N, N, 0, 0, N},
            '{ 7, 2,51,31,46,23,16,11,53,40,10, 7,46,53,33,35, N,25,35,38, 0, N, 0, 0},
            '{19,48,41, 1,10, 7,36,47, 5,29,52,52,31,10,26, 6, 3, 2, N,51, 1, N, N, 0}
        },
        '{  // n=1944, Z=81
            '{13,48,80,66, 4,74, 7,30,76,52,37,60, N,49,73,31,74,73,23, N, 1, 0, N, N},
            '{69,63,74,56,64,77,57,65, 6,16,51, N,64, N,68, 9,48,62,54,27, N, 0, 0, N},
            '{51,15, 0,80,24,25,42,54,44,71,71, 9,67,35, N,58, N,29, N,53, 0, N, 0, 0},
            '{16,29,36,41,44,56,59,37,50,24, N,65, 4,65,52, N, 4, N,73,52, 1, N, N, 0}
        }
    };

    function automatic logic [SHIFT_W-1:0] enc(input int v);
        return (v < 0) ? SHIFT_NULL : SHIFT_W'(v);
    endfunction

    always_comb begin
        shifts = '1;
        if (z_idx < 2'd3 && col < COL_W'(NUM_COLS)) begin
            for (int r = 0; r < NUM_PARITY_BLKS_PER_CODE_BLK; r++)
                shifts[r*SHIFT_W +: SHIFT_W] = enc(H_TAB[z_idx][r][col]);
        end
    end

endmodule

// File: rtl/qc_ldpc_syndrome_checker.sv
// Two-stage syndrome accumulator over 24 column blocks; result 2 cycles after the last
// column accept, held with out_valid until out_ready. Input stalls only on in_valid gaps.
module qc_ldpc_syndrome_checker
    import qc_ldpc_pkg::*;
(
    input  logic                                            CLK,
    input  logic                                            rst_n,
    input  logic                                            start,
    input  logic [NUM_OF_SUPPORTED_Z-1:0]                   z_sel,
    output logic                                            busy,
    output logic                                            cfg_err,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [MAX_Z-1:0]                                in_data,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [NUM_PARITY_BLKS_PER_CODE_BLK*MAX_Z-1:0]   syndrome,
    output logic                                            syndrome_ok
);

    localparam int NP = NUM_PARITY_BLKS_PER_CODE_BLK;

    state_t                  state;
    logic [1:0]              z_idx;
    logic [SHIFT_W-1:0]      z_val;
    logic [COL_W-1:0]        col;
    logic                    s1_vld;
    logic [MAX_Z-1:0]        s1_dat;
    logic [COL_W-1:0]        s1_col;
    logic [NP*SHIFT_W-1:0]   s1_shift;
    logic [NP*MAX_Z-1:0]     acc;
    logic [NP*MAX_Z-1:0]     acc_nxt;
    logic                    in_fire;

    assign z_val   = z_of_idx(z_idx);
    assign in_fire = in_valid & in_ready;

    qc_ldpc_shift_lut u_lut (
        .z_idx  (z_idx),
        .col    (s1_col),
        .shifts (s1_shift)
    );

    always_comb begin
        acc_nxt = acc;
        if (s1_vld) begin
            for (int r = 0; r < NP; r++)
                if (s1_shift[r*SHIFT_W +: SHIFT_W] != SHIFT_NULL)
                    acc_nxt[r*MAX_Z +: MAX_Z] = acc[r*MAX_Z +: MAX_Z]
                        ^ rot_z(s1_dat, s1_shift[r*SHIFT_W +: SHIFT_W], z_val);
        end
    end

    function automatic logic [1:0] onehot_idx(input logic [NUM_OF_SUPPORTED_Z-1:0] oh);
        return oh[1] ? 2'd1 : (oh[2] ? 2'd2 : 2'd0);
    endfunction

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            cfg_err     <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            syndrome    <= '0;
            syndrome_ok <= 1'b0;
            z_idx       <= '0;
            col         <= '0;
            s1_vld      <= 1'b0;
            s1_dat      <= '0;
            s1_col      <= '0;
            acc         <= '0;
        end else begin
            cfg_err <= 1'b0;
            s1_vld  <= in_fire;
            acc     <= acc_nxt;
            if (in_fire) begin
                s1_dat <= in_data & z_mask(z_val);
                s1_col <= col;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if ($onehot(z_sel)) begin
                            z_idx    <= onehot_idx(z_sel);
                            acc      <= '0;
                            col      <= '0;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                            state    <= ACCUM;
                        end else begin
                            cfg_err  <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_fire) begin
                        col <= col + 1'b1;
                        if (col == COL_W'(NUM_COLS - 1)) begin
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: state <= DONE;
                DONE: begin
                    // First DONE cycle captures the fully retired accumulator.
                    if (!out_valid) begin
                        syndrome    <= acc;
                        syndrome_ok <= ~|acc;
                        out_valid   <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
